load_store_unit: RTL and testbench
==================================

# load_store_unit

Core-side initiator for the byte-array data memory. Accepts one load or store at a time from the execute stage over a valid/ready handshake and drives the memory's `addr`/`wdata`/`wenable`/`renable` strobes. It captures `rdata`, which the memory returns one cycle after `renable`. The memory transfers big-endian 32-bit words only, so this block implements byte and halfword stores as read-modify-write and extracts sub-word loads with sign or zero extension.

## Interface
Parameters:
- `MEM_BYTES`, default 1024: memory size in bytes; must be a multiple of 4.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_signed` in 1: sign-extend sub-word loads.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result; held until the next response.
- `resp_err` out 1: request faulted; qualified by `resp_valid`.
- `mem_addr` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_wdata` out 32: full word to write.
- `mem_wenable` out 1: write strobe.
- `mem_renable` out 1: read strobe.
- `mem_rdata` in 32: memory read data.

## Operation
- Request fields are latched on the edge where `req_valid & req_ready`. Inputs are ignored in every other state.
- Byte lanes are big-endian. Offset o = `addr[1:0]` selects bits `[31-8o -: 8]`. A half at offset 0 uses `[31:16]`; a half at offset 2 uses `[15:0]`.
- Error checks run at accept time, with no memory access on error:
  - `req_size`=11.
  - Half with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - `req_addr` ≥ `MEM_BYTES`.
- FSM states and transitions:
  - IDLE: `req_ready`=1. On accept, go to ERR if a check fails. Otherwise a load or sub-word store goes to RD, and a word store goes to WR.
  - RD: `mem_renable`=1. Next state is WAIT.
  - WAIT: `mem_rdata` is valid here. A load registers the extracted and extended value and goes to RESP. A sub-word store registers the merged word (old word with the addressed lane(s) replaced by `req_wdata[7:0]` or `[15:0]`) and goes to WR.
  - WR: `mem_wenable`=1 and `mem_wdata` = store word (`req_wdata` for a word store, the merged word otherwise). Next state is RESP.
  - RESP: `resp_valid`=1 and `resp_err`=0. Next state is IDLE.
  - ERR: `resp_valid`=1, `resp_err`=1, `resp_rdata` unchanged. Next state is IDLE.
- Strobe rules:
  - `mem_renable` and `mem_wenable` are never high together.
  - Each is high for exactly one cycle per access.
  - Both are low outside RD and WR.
  - `mem_addr` is held stable from RD through WR.
- Loads update `resp_rdata`. Stores leave `resp_rdata` unchanged.

## Timing
- Reset values: state IDLE; `req_ready`=1; `resp_valid`=0; `resp_err`=0; `resp_rdata`=0; `mem_addr`=0; `mem_wdata`=0; `mem_wenable`=0; `mem_renable`=0.
- All outputs decode from registered state and latched fields. No input-to-output combinational path exists.
- Latency, counted in cycles after the accept edge until `resp_valid` is high:
  - Load: 3.
  - Word store: 2.
  - Sub-word store: 4.
  - Error: 1.
- Throughput is one request in flight. `req_ready` returns in the cycle after RESP or ERR.
- `rst` asserted in any state forces IDLE immediately, drops any pending strobe in the same cycle, and discards the request. A store aborted before WR leaves memory untouched.

## Configuration
- `LSU_SUBWORD_EN` defined: byte and half loads and stores are supported as described above.
- Not defined:
  - `req_size` 00 and 01 are treated as illegal and go to ERR.
  - Only word accesses reach memory.
  - The extraction, extension and merge logic is removed.

## Test plan
- After reset, word load 0x10 -> `mem_renable` high for 1 cycle with `mem_addr`=0x10; `resp_rdata`=0x00000010 with `resp_valid` 3 cycles after accept.
- Byte load 0x83: signed -> `resp_rdata`=0xFFFFFF80; unsigned -> 0x00000080.
- Byte store 0xAB at 0x21 -> RD, WR sequence with `mem_wdata`=0x00AB0020; a subsequent word load 0x20 returns 0x00AB0020.
- Word store 0x12345678 at 0x40 -> `mem_renable` never high, `mem_wenable` high for 1 cycle, `resp_valid` 2 cycles after accept. A half store 0xBEEF at 0x42 followed by a word load 0x40 then returns 0x1234BEEF.
- Word load at 0x06, and word load at 0x400 -> `resp_valid` and `resp_err` high 1 cycle after accept; no memory strobes.
- `rst` pulsed during WAIT of a byte store -> `mem_wenable` never asserts and `req_ready`=1 immediately. With `LSU_SUBWORD_EN` undefined, byte load 0x10 -> `resp_err`=1.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store initiator for a big-endian, word-only data memory with one-cycle read latency.
// Define LSU_SUBWORD_EN to enable byte/half loads (with extension) and read-modify-write stores.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wenable,
    output logic        mem_renable,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_RESP,
        S_ERR
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] store_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        bad;
    logic        word_store;
    logic [31:0] load_val;

`ifdef LSU_SUBWORD_EN
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] merge_val;
`else
    logic        unused_subword;
    assign unused_subword = req_signed;
`endif

    assign accept     = req_valid && (state == S_IDLE);
    assign word_store = req_we && (req_size == 2'b10);

    // Fault checks evaluated on the raw request so ERR is decided at accept time
    always_comb begin
        bad = (req_addr >= 32'(MEM_BYTES));
`ifdef LSU_SUBWORD_EN
        case (req_size)
            2'b00:   bad = bad;
            2'b01:   if (req_addr[0]) bad = 1'b1;
            2'b10:   if (req_addr[1:0] != 2'b00) bad = 1'b1;
            default: bad = 1'b1;
        endcase
`else
        if (req_size != 2'b10 || req_addr[1:0] != 2'b00) bad = 1'b1;
`endif
    end

`ifdef LSU_SUBWORD_EN
    // Lane 0 is the most significant byte of the memory word
    always_comb begin
        byte_sel  = 8'h00;
        merge_val = mem_rdata;
        case (off_q)
            2'd0: begin byte_sel = mem_rdata[31:24]; merge_val[31:24] = wdata_q[7:0]; end
            2'd1: begin byte_sel = mem_rdata[23:16]; merge_val[23:16] = wdata_q[7:0]; end
            2'd2: begin byte_sel = mem_rdata[15:8];  merge_val[15:8]  = wdata_q[7:0]; end
            default: begin byte_sel = mem_rdata[7:0]; merge_val[7:0] = wdata_q[7:0]; end
        endcase
        half_sel = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        load_val = mem_rdata;
        if (size_q == 2'b00) begin
            load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
        end else if (size_q == 2'b01) begin
            load_val = {{16{signed_q & half_sel[15]}}, half_sel};
            if (off_q[1]) merge_val = {mem_rdata[31:16], wdata_q[15:0]};
            else          merge_val = {wdata_q[15:0], mem_rdata[15:0]};
        end
    end
`else
    assign load_val = mem_rdata;
`endif

    always_comb begin
        state_next  = state;
        req_ready   = 1'b0;
        mem_renable = 1'b0;
        mem_wenable = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (bad)             state_next = S_ERR;
                    else if (word_store) state_next = S_WR;
                    else                 state_next = S_RD;
                end
            end
            S_RD: begin
                mem_renable = 1'b1;
                state_next  = S_WAIT;
            end
            S_WAIT: state_next = we_q ? S_WR : S_RESP;
            S_WR: begin
                mem_wenable = 1'b1;
                state_next  = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_next = S_IDLE;
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = store_q;
    assign resp_rdata = rdata_q;

    // Faulting requests leave the memory-facing registers untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            store_q  <= 32'h0;
            rdata_q  <= 32'h0;
`ifdef LSU_SUBWORD_EN
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
            wdata_q  <= 32'h0;
`endif
        end else begin
            state <= state_next;
            if (accept && !bad) begin
                we_q   <= req_we;
                addr_q <= {req_addr[31:2], 2'b00};
                if (word_store) store_q <= req_wdata;
`ifdef LSU_SUBWORD_EN
                size_q   <= req_size;
                signed_q <= req_signed;
                off_q    <= req_addr[1:0];
                wdata_q  <= req_wdata;
`endif
            end
            if (state == S_WAIT) begin
`ifdef LSU_SUBWORD_EN
                if (we_q) store_q <= merge_val;
                else      rdata_q <= load_val;
`else
                rdata_q <= load_val;
`endif
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit against a byte-array memory model
// whose word at address A initially holds the value A.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wenable;
    logic        mem_renable;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem [0:1023];
    logic [9:0]  widx;

    int          r_lat;
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_rd;
    int          r_wr;
    logic [31:0] r_wword;
    logic [31:0] r_raddr;
    logic [31:0] r_waddr;
    logic        r_both;
    logic [31:0] exp_hold;

    load_store_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wenable(mem_wenable), .mem_renable(mem_renable), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign widx = {mem_addr[9:2], 2'b00};

    // Big-endian memory, read data returned one cycle after the read strobe
    always @(posedge clk) begin
        if (mem_renable)
            mem_rdata <= {mem[widx], mem[widx + 10'd1], mem[widx + 10'd2], mem[widx + 10'd3]};
        if (mem_wenable) begin
            mem[widx]         <= mem_wdata[31:24];
            mem[widx + 10'd1] <= mem_wdata[23:16];
            mem[widx + 10'd2] <= mem_wdata[15:8];
            mem[widx + 10'd3] <= mem_wdata[7:0];
        end
    end

    task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hDEAD_BEEF;
        r_lat = 0; r_rdata = 32'hX; r_err = 1'bX; r_rd = 0; r_wr = 0;
        r_wword = 32'hX; r_raddr = 32'hX; r_waddr = 32'hX; r_both = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_renable) begin r_rd++; r_raddr = mem_addr; end
            if (mem_wenable) begin r_wr++; r_wword = mem_wdata; r_waddr = mem_addr; end
            if (mem_renable && mem_wenable) r_both = 1'b1;
            if (resp_valid) begin
                r_lat = c; r_rdata = resp_rdata; r_err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp got %b%b want 00", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata got %h want 0", resp_rdata); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (mem_renable !== 1'b0 || mem_wenable !== 1'b0) begin errors++; $display("[TB] FAIL rst_strobes got %b%b want 00", mem_renable, mem_wenable); end
        rst = 1'b0;
        exp_hold = 32'h0;
    endtask

    task automatic test_word_load;
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++; if (r_lat !== 3) begin errors++; $display("[TB] FAIL wl_latency got %0d want 3", r_lat); end
        checks++; if (r_rd !== 1 || r_wr !== 0) begin errors++; $display("[TB] FAIL wl_strobes got rd=%0d wr=%0d want 1/0", r_rd, r_wr); end
        checks++; if (r_raddr !== 32'h10) begin errors++; $display("[TB] FAIL wl_addr got %h want 00000010", r_raddr); end
        checks++; if (r_rdata !== 32'h10 || r_err !== 1'b0) begin errors++; $display("[TB] FAIL wl_data got %h err=%b want 00000010 err=0", r_rdata, r_err); end
        exp_hold = 32'h10;
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("[TB] FAIL wl_pulse got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
        checks++; if (resp_rdata !== 32'h10) begin errors++; $display("[TB] FAIL wl_hold got %h want 00000010", resp_rdata); end
    endtask

    task automatic test_byte_load;
`ifdef LSU_SUBWORD_EN
        run_req(1'b0, 2'b00, 1'b1, 32'h83, 32'h0);
        checks++; if (r_rdata !== 32'hFFFF_FF80 || r_lat !== 3) begin errors++; $display("[TB] FAIL bl_signed got %h lat=%0d want ffffff80 lat=3", r_rdata, r_lat); end
        run_req(1'b0, 2'b00, 1'b0, 32'h83, 32'h0);
        checks++; if (r_rdata !== 32'h0000_0080 || r_err !== 1'b0) begin errors++; $display("[TB] FAIL bl_unsigned got %h err=%b want 00000080 err=0", r_rdata, r_err); end
        exp_hold = 32'h80;
        run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        checks++; if (r_rdata !== 32'h0000_0000) begin errors++; $display("[TB] FAIL bl_lane2 got %h want 00000000", r_rdata); end
        exp_hold = 32'h0;
`else
        run_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        checks++; if (r_err !== 1'b1 || r_lat !== 1) begin errors++; $display("[TB] FAIL bl_disabled got err=%b lat=%0d want err=1 lat=1", r_err, r_lat); end
        checks++; if (r_rd !== 0 || r_wr !== 0) begin errors++; $display("[TB] FAIL bl_disabled_strobes got rd=%0d wr=%0d want 0/0", r_rd, r_wr); end
        checks++; if (r_rdata !== exp_hold) begin errors++; $display("[TB] FAIL bl_disabled_hold got %h want %h", r_rdata, exp_hold); end
`endif
    endtask

    task automatic test_byte_store;
        run_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_56AB);
`ifdef LSU_SUBWORD_EN
        checks++; if (r_lat !== 4 || r_err !== 1'b0) begin errors++; $display("[TB] FAIL bs_latency got %0d err=%b want 4 err=0", r_lat, r_err); end
        checks++; if (r_rd !== 1 || r_wr !== 1 || r_both !== 1'b0) begin errors++; $display("[TB] FAIL bs_strobes got rd=%0d wr=%0d both=%b want 1/1/0", r_rd, r_wr, r_both); end
        checks++; if (r_wword !== 32'h00AB_0020) begin errors++; $display("[TB] FAIL bs_wdata got %h want 00ab0020", r_wword); end
        checks++; if (r_raddr !== 32'h20 || r_waddr !== 32'h20) begin errors++; $display("[TB] FAIL bs_addr got %h/%h want 00000020", r_raddr, r_waddr); end
        checks++; if (r_rdata !== exp_hold) begin errors++; $display("[TB] FAIL bs_rdata_hold got %h want %h", r_rdata, exp_hold); end
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        checks++; if (r_rdata !== 32'h00AB_0020) begin errors++; $display("[TB] FAIL bs_readback got %h want 00ab0020", r_rdata); end
        exp_hold = 32'h00AB_0020;
`else
        checks++; if (r_err !== 1'b1 || r_wr !== 0) begin errors++; $display("[TB] FAIL bs_disabled got err=%b wr=%0d want err=1 wr=0", r_err, r_wr); end
        run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        checks++; if (r_rdata !== 32'h0000_0020) begin errors++; $display("[TB] FAIL bs_readback got %h want 00000020", r_rdata); end
        exp_hold = 32'h20;
`endif
    endtask

    task automatic test_word_store;
        run_req(1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678);
        checks++; if (r_lat !== 2 || r_err !== 1'b0) begin errors++; $display("[TB] FAIL ws_latency got %0d err=%b want 2 err=0", r_lat, r_err); end
        checks++; if (r_rd !== 0 || r_wr !== 1) begin errors++; $display("[TB] FAIL ws_strobes got rd=%0d wr=%0d want 0/1", r_rd, r_wr); end
        checks++; if (r_wword !== 32'h1234_5678 || r_waddr !== 32'h40) begin errors++; $display("[TB] FAIL ws_write got %h@%h want 12345678@00000040", r_wword, r_waddr); end
        checks++; if (r_rdata !== exp_hold) begin errors++; $display("[TB] FAIL ws_rdata_hold got %h want %h", r_rdata, exp_hold); end
        run_req(1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_BEEF);
        run_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
`ifdef LSU_SUBWORD_EN
        checks++; if (r_rdata !== 32'h1234_BEEF) begin errors++; $display("[TB] FAIL hs_readback got %h want 1234beef", r_rdata); end
        run_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0);
        checks++; if (r_rdata !== 32'hFFFF_BEEF) begin errors++; $display("[TB] FAIL hl_signed got %h want ffffbeef", r_rdata); end
        run_req(1'b0, 2'b01, 1'b1, 32'h40, 32'h0);
        checks++; if (r_rdata !== 32'h0000_1234) begin errors++; $display("[TB] FAIL hl_upper got %h want 00001234", r_rdata); end
        exp_hold = 32'h0000_1234;
`else
        checks++; if (r_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL hs_readback got %h want 12345678", r_rdata); end
        exp_hold = 32'h1234_5678;
`endif
    endtask

    task automatic test_errors;
        run_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
        checks++; if (r_err !== 1'b1 || r_lat !== 1) begin errors++; $display("[TB] FAIL err_misaligned got err=%b lat=%0d want 1/1", r_err, r_lat); end
        checks++; if (r_rd !== 0 || r_wr !== 0) begin errors++; $display("[TB] FAIL err_misaligned_strobes got rd=%0d wr=%0d want 0/0", r_rd, r_wr); end
        checks++; if (r_rdata !== exp_hold) begin errors++; $display("[TB] FAIL err_rdata_hold got %h want %h", r_rdata, exp_hold); end
        run_req(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        checks++; if (r_err !== 1'b1 || r_lat !== 1 || r_rd !== 0) begin errors++; $display("[TB] FAIL err_range got err=%b lat=%0d rd=%0d want 1/1/0", r_err, r_lat, r_rd); end
        run_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h0);
        checks++; if (r_err !== 1'b1 || r_wr !== 0) begin errors++; $display("[TB] FAIL err_size got err=%b wr=%0d want 1/0", r_err, r_wr); end
        run_req(1'b1, 2'b01, 1'b0, 32'h41, 32'h0);
        checks++; if (r_err !== 1'b1 || r_rd !== 0 || r_wr !== 0) begin errors++; $display("[TB] FAIL err_half_odd got err=%b rd=%0d wr=%0d want 1/0/0", r_err, r_rd, r_wr); end
        run_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
        checks++; if (r_err !== 1'b0 || r_rdata !== 32'h3FC) begin errors++; $display("[TB] FAIL top_word got %h err=%b want 000003fc err=0", r_rdata, r_err); end
    endtask

    task automatic test_reset_abort;
        int wr_seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_signed = 1'b0;
`ifdef LSU_SUBWORD_EN
        req_size = 2'b00; req_addr = 32'h51; req_wdata = 32'h77;
`else
        req_size = 2'b10; req_addr = 32'h50; req_wdata = 32'h7777_7777;
`endif
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
`ifdef LSU_SUBWORD_EN
        @(negedge clk);
`endif
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || mem_wenable !== 1'b0 || mem_renable !== 1'b0) begin errors++; $display("[TB] FAIL abort_now got ready=%b we=%b re=%b want 1/0/0", req_ready, mem_wenable, mem_renable); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL abort_rdata got %h want 0", resp_rdata); end
        @(negedge clk);
        rst = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_wenable || resp_valid) wr_seen++;
        end
        checks++; if (wr_seen !== 0) begin errors++; $display("[TB] FAIL abort_quiet got %0d want 0", wr_seen); end
        run_req(1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
        checks++; if (r_rdata !== 32'h50) begin errors++; $display("[TB] FAIL abort_mem got %h want 00000050", r_rdata); end
    endtask

    initial begin
        for (int a = 0; a < 1024; a += 4) begin
            mem[a]     = 8'(a >> 24);
            mem[a + 1] = 8'(a >> 16);
            mem[a + 2] = 8'(a >> 8);
            mem[a + 3] = 8'(a);
        end
        test_reset();
        test_word_load();
        test_byte_load();
        test_byte_store();
        test_word_store();
        test_errors();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
